// File: rtl/adder_pkg.sv
// Shared constants and helpers for the adder-sharing arbiter slice.
package adder_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned CNT_W_DEF   = 16;

  // Tag width for n requesters; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/kogge_stone_adder.sv
// Combinational parallel-prefix adder, carry-in fixed at 0.
module kogge_stone_adder
  import adder_pkg::*;
#(
  parameter int unsigned W = DATA_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  localparam int unsigned Levels = $clog2(W);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W-1:0] gn;
  logic [W-1:0] pn;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gn = g;
    pn = p;
    for (int l = 0; l < int'(Levels); l++) begin
      gn = g;
      pn = p;
      for (int i = (1 << l); i < int'(W); i++) begin
        gn[i] = g[i] | (p[i] & g[i - (1 << l)]);
        pn[i] = p[i] & p[i - (1 << l)];
      end
      g = gn;
      p = pn;
    end
    // After the full prefix, g[i] is the carry out of bits [i:0].
    sum = (a ^ b) ^ {g[W-2:0], 1'b0};
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requesting index at or after ptr, wrapping upward.
module rr_arbiter
  import adder_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  logic found;
  int   idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      idx = (int'(ptr) + i) % int'(NUM_REQ);
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one adder among NUM_REQ requesters through an operand stage and a result stage.
module adder_share_arbiter
  import adder_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned ID_W    = id_width(NUM_REQ),
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_a,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_b,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic                      o_rsp_valid,
  output logic [DATA_W-1:0]         o_rsp_sum,
  output logic                      o_rsp_carry,
  output logic [ID_W-1:0]           o_rsp_id,
  input  logic                      i_rsp_ready,
  output logic [CNT_W-1:0]          o_op_cnt
);

  logic              advance1, advance2, accept;
  logic [ID_W-1:0]   gnt_id, ptr_q;
  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_a_q, s1_b_q, sel_a, sel_b, add_sum;
  logic [ID_W-1:0]   s1_id_q;
  logic              rsp_valid_q, rsp_carry_q;
  logic [DATA_W-1:0] rsp_sum_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [CNT_W-1:0]  cnt_q;

  assign advance2 = ~rsp_valid_q | i_rsp_ready;
  assign advance1 = ~s1_valid_q | advance2;

  // Gating with reset keeps every ready bit low while the block is held in reset.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req    (i_req_valid),
    .ptr    (ptr_q),
    .en     (advance1 & i_rst_n),
    .gnt    (o_req_ready),
    .gnt_id (gnt_id)
  );

  assign accept = |(i_req_valid & o_req_ready);
  assign sel_a  = i_req_a[int'(gnt_id)*DATA_W +: DATA_W];
  assign sel_b  = i_req_b[int'(gnt_id)*DATA_W +: DATA_W];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
      ptr_q      <= '0;
    end else if (advance1) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_a_q  <= sel_a;
        s1_b_q  <= sel_b;
        s1_id_q <= gnt_id;
        ptr_q   <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
      end
    end
  end

  kogge_stone_adder #(
    .W (DATA_W)
  ) u_add (
    .a   (s1_a_q),
    .b   (s1_b_q),
    .sum (add_sum)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
      rsp_id_q    <= '0;
    end else if (advance2) begin
      rsp_valid_q <= s1_valid_q;
      rsp_sum_q   <= add_sum;
      rsp_carry_q <= (s1_a_q[DATA_W-1] & s1_b_q[DATA_W-1]) |
                     ((s1_a_q[DATA_W-1] ^ s1_b_q[DATA_W-1]) & ~add_sum[DATA_W-1]);
      rsp_id_q    <= s1_id_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (rsp_valid_q && i_rsp_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_sum   = rsp_sum_q;
  assign o_rsp_carry = rsp_carry_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_op_cnt    = cnt_q;

endmodule
